// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and sizing helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    localparam int unsigned LAT_MAX = 15;
    localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

    // Word-index width for a power-of-two depth; never below one bit.
    function automatic int unsigned word_idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous word array with a registered read port.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int unsigned NBITS = 32,
    parameter int unsigned AW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic             rd_clr,
    input  logic             wr_en,
    input  logic [AW-1:0]    idx,
    input  logic [NBITS-1:0] wdata,
    output logic [NBITS-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [NBITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wdata;
        end
    end

    // rd_clr forces a zero result instead of the stored word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_clr ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder, one request in flight.
// Define DMEM_MISALIGN_ERR_EN to flag and suppress misaligned accesses on err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned NBITS       = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             proc_req,
    input  logic [NBITS-1:0] addr,
    input  logic             we,
    input  logic [NBITS-1:0] wdata,
    output logic             mem_rdy,
    output logic             valid,
    output logic [NBITS-1:0] rdata,
    output logic             err
);

    localparam int unsigned AW        = word_idx_w(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    dmem_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    idx_q;
    logic             we_q;
    logic [NBITS-1:0] wdata_q;
    logic             mis_q;

    logic          accept_c;
    logic          mis_c;
    logic          mis_sel_c;
    logic          we_sel_c;
    logic          to_resp_c;
    logic          ram_rd_c;
    logic          ram_wr_c;
    logic [AW-1:0] ram_idx_c;
    logic          unused_addr;

    assign mem_rdy  = (state == IDLE) && !rst;
    assign accept_c = proc_req && mem_rdy;

`ifdef DMEM_MISALIGN_ERR_EN
    assign mis_c = (addr[1:0] != 2'b00);
`else
    assign mis_c = 1'b0;
`endif

    // Bits above the word index alias; byte-offset bits only matter for err.
    assign unused_addr = ^{addr[NBITS-1:AW+2], addr[1:0]};

    // In IDLE the live request drives the array; afterwards the captured copy does.
    assign ram_idx_c = (state == IDLE) ? addr[AW+1:2] : idx_q;
    assign mis_sel_c = (state == IDLE) ? mis_c : mis_q;
    assign we_sel_c  = (state == IDLE) ? we : we_q;

    // Read launches one cycle before RESP so registered rdata lines up with valid.
    assign to_resp_c = !rst && ((accept_c && (LATENCY == 1)) ||
                                ((state == WAIT) && (cnt == CNT_ONE)));
    assign ram_rd_c  = to_resp_c && !we_sel_c;
    assign ram_wr_c  = !rst && (state == RESP) && we_q && !mis_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            valid <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    err   <= 1'b0;
                    if (accept_c) begin
                        cnt     <= CNT_LOAD;
                        idx_q   <= addr[AW+1:2];
                        we_q    <= we;
                        wdata_q <= wdata;
                        mis_q   <= mis_c;
                        if (LATENCY == 1) begin
                            state <= RESP;
                            valid <= 1'b1;
                            err   <= mis_c;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CNT_ONE) begin
                        state <= RESP;
                        valid <= 1'b1;
                        err   <= mis_q;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

    dmem_ram #(
        .NBITS (NBITS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .rd_en (ram_rd_c),
        .rd_clr(mis_sel_c),
        .wr_en (ram_wr_c),
        .idx   (ram_idx_c),
        .wdata (ram_wr_c ? wdata_q : wdata_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (latency 2 and 1) share one random stimulus
// stream and are checked every cycle against a timestamp-based reference model.
module tb_dmem_responder;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        proc_req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  d_rdy;
    logic [1:0]  d_valid;
    logic [1:0]  d_err;
    logic [31:0] d_rdata0;
    logic [31:0] d_rdata1;

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(.NBITS(32), .DEPTH_WORDS(1024), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst(rst), .proc_req(proc_req), .addr(addr), .we(we), .wdata(wdata),
        .mem_rdy(d_rdy[0]), .valid(d_valid[0]), .rdata(d_rdata0), .err(d_err[0])
    );

    dmem_responder #(.NBITS(32), .DEPTH_WORDS(1024), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst(rst), .proc_req(proc_req), .addr(addr), .we(we), .wdata(wdata),
        .mem_rdy(d_rdy[1]), .valid(d_valid[1]), .rdata(d_rdata1), .err(d_err[1])
    );

    initial forever #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired", name);
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [31:0] rdata_of(input int i);
        return (i == 0) ? d_rdata0 : d_rdata1;
    endfunction

    // Reference model: a request accepted in cycle T answers in T+LAT and the
    // write lands in the array at the end of that cycle.
    int          cyc = 0;
    bit          live = 1'b0;
    bit          m_txn   [2];
    int          m_due   [2];
    logic [9:0]  m_idx   [2];
    bit          m_we    [2];
    bit          m_mis   [2];
    logic [31:0] m_wd    [2];
    logic [31:0] m_mem   [2][1024];
    bit          m_has   [2][1024];
    bit          e_valid [2];
    bit          e_err   [2];
    logic [31:0] e_rdata [2];
    bit          e_rknown[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_txn[i] = 1'b0; e_valid[i] = 1'b0; e_err[i] = 1'b0;
            e_rdata[i] = '0; e_rknown[i] = 1'b0;
            for (int w = 0; w < 1024; w++) m_has[i][w] = 1'b0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    m_txn[i] = 1'b0;
                    e_rdata[i] = '0;
                    e_rknown[i] = 1'b1;
                end else if (m_txn[i]) begin
                    if (cyc == m_due[i]) begin
                        if (m_we[i] && !m_mis[i]) begin
                            m_mem[i][m_idx[i]] = m_wd[i];
                            m_has[i][m_idx[i]] = 1'b1;
                        end
                        m_txn[i] = 1'b0;
                    end
                end else if (proc_req) begin
                    m_txn[i] = 1'b1;
                    m_due[i] = cyc + lat_of(i);
                    m_idx[i] = addr[11:2];
                    m_we[i]  = we;
                    m_wd[i]  = wdata;
                    m_mis[i] = MIS_EN && (addr[1:0] != 2'b00);
                end
            end
            if (rst) live = 1'b1;
            cyc++;
            for (int i = 0; i < 2; i++) begin
                e_valid[i] = m_txn[i] && (cyc == m_due[i]);
                e_err[i]   = e_valid[i] && m_mis[i];
                if (e_valid[i] && !m_we[i]) begin
                    if (m_mis[i]) begin
                        e_rdata[i] = '0;
                        e_rknown[i] = 1'b1;
                    end else begin
                        e_rdata[i] = m_mem[i][m_idx[i]];
                        e_rknown[i] = m_has[i][m_idx[i]];
                    end
                end
            end
        end
    end

    // Compare process: every cycle, both instances, on the falling edge.
    initial forever begin
        @(negedge clk);
        if (live) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("mem_rdy[%0d] cyc %0d", i, cyc), 32'(d_rdy[i]), 32'(!rst && !m_txn[i]));
                chk($sformatf("valid[%0d] cyc %0d", i, cyc), 32'(d_valid[i]), 32'(e_valid[i]));
                chk($sformatf("err[%0d] cyc %0d", i, cyc), 32'(d_err[i]), 32'(e_err[i]));
                if (e_rknown[i])
                    chk($sformatf("rdata[%0d] cyc %0d", i, cyc), rdata_of(i), e_rdata[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction as seen by the latency-2 instance.
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er,
                          output int wait_rdy, output int lat_k);
        bit got;
        rd = '0; er = 1'b0; wait_rdy = -1; lat_k = -1;
        proc_req = 1'b1; we = w; addr = a; wdata = d;
        got = 1'b0;
        for (int k = 0; k < 32 && !got; k++) begin
            if (d_rdy[0]) begin
                got = 1'b1;
                wait_rdy = k;
            end else begin
                step();
            end
        end
        step();
        proc_req = 1'b0;
        if (!got) begin
            fail_now("txn_accept_timeout");
            return;
        end
        got = 1'b0;
        for (int k = 0; k < 32 && !got; k++) begin
            @(negedge clk);
            if (d_valid[0]) begin
                got = 1'b1;
                lat_k = k;
                rd = d_rdata0;
                er = d_err[0];
            end
            @(posedge clk);
            #1;
        end
        if (!got) fail_now("txn_valid_timeout");
    endtask

    logic [31:0] rd;
    logic        er;
    int          wr_wait, wr_lat;

    initial begin
        rst = 1'b1; proc_req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        step();
        @(negedge clk);
        chk("rst_mem_rdy", 32'(d_rdy[0]), 32'd0);
        @(posedge clk); #1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_mem_rdy", 32'(d_rdy[0]), 32'd1);
        chk("post_rst_valid", 32'(d_valid[0]), 32'd0);
        chk("post_rst_rdata", d_rdata0, 32'd0);
        @(posedge clk); #1;

        // Write then read back at latency 2.
        do_txn(1'b1, 32'h40, 32'hDEADBEEF, rd, er, wr_wait, wr_lat);
        chk("wr_lat", 32'(wr_lat), 32'd1);
        do_txn(1'b0, 32'h40, 32'h0, rd, er, wr_wait, wr_lat);
        chk("rd_accept_wait", 32'(wr_wait), 32'd0);
        chk("rd_lat", 32'(wr_lat), 32'd1);
        chk("rd_deadbeef", rd, 32'hDEADBEEF);

        // Address wrap at 1024 words.
        do_txn(1'b1, 32'h0000_1000, 32'h11, rd, er, wr_wait, wr_lat);
        do_txn(1'b0, 32'h0, 32'h0, rd, er, wr_wait, wr_lat);
        chk("wrap_rdata", rd, 32'h11);

        // proc_req held high while busy: only accepted requests write.
        do_txn(1'b1, 32'h204, 32'h5555, rd, er, wr_wait, wr_lat);
        for (int k = 0; k < 9; k++) begin
            proc_req = 1'b1; we = 1'b1;
            addr = 32'h200 + 32'(4 * k);
            wdata = 32'hA000 + 32'(k);
            step();
        end
        proc_req = 1'b0;
        repeat (3) step();
        do_txn(1'b0, 32'h204, 32'h0, rd, er, wr_wait, wr_lat);
        chk("hold_ignored_204", rd, 32'h5555);
        do_txn(1'b0, 32'h200, 32'h0, rd, er, wr_wait, wr_lat);
        chk("hold_200", rd, 32'hA000);
        do_txn(1'b0, 32'h20C, 32'h0, rd, er, wr_wait, wr_lat);
        chk("hold_20c", rd, 32'hA003);
        do_txn(1'b0, 32'h218, 32'h0, rd, er, wr_wait, wr_lat);
        chk("hold_218", rd, 32'hA006);

        // Reset during WAIT abandons the write.
        do_txn(1'b1, 32'h80, 32'h66, rd, er, wr_wait, wr_lat);
        proc_req = 1'b1; we = 1'b1; addr = 32'h80; wdata = 32'h77;
        step();
        proc_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid_wait", 32'(d_valid[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid_after", 32'(d_valid[0]), 32'd0);
        @(posedge clk); #1;
        step();
        do_txn(1'b0, 32'h80, 32'h0, rd, er, wr_wait, wr_lat);
        chk("abort_old_data", rd, 32'h66);

`ifdef DMEM_MISALIGN_ERR_EN
        do_txn(1'b0, 32'h42, 32'h0, rd, er, wr_wait, wr_lat);
        chk("mis_rd_err", 32'(er), 32'd1);
        chk("mis_rd_rdata", rd, 32'd0);
        do_txn(1'b1, 32'h81, 32'h99, rd, er, wr_wait, wr_lat);
        chk("mis_wr_err", 32'(er), 32'd1);
        do_txn(1'b0, 32'h80, 32'h0, rd, er, wr_wait, wr_lat);
        chk("mis_wr_suppressed", rd, 32'h66);
`else
        do_txn(1'b0, 32'h42, 32'h0, rd, er, wr_wait, wr_lat);
        chk("offset_ignored_err", 32'(er), 32'd0);
        chk("offset_ignored_rdata", rd, 32'hDEADBEEF);
`endif

        // Random traffic with aliased addresses and occasional reset.
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 63) == 0);
            proc_req = 1'($urandom_range(0, 1));
            we       = 1'($urandom_range(0, 1));
            addr     = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2)
                     | 32'($urandom_range(0, 3));
            wdata    = $urandom;
            step();
        end
        rst = 1'b0;
        proc_req = 1'b0;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory request interface.
- Accepts one request at a time on the `proc_req`/`mem_rdy` handshake and models a fixed access latency.
- Performs the word read or write on an internal word array and returns a single-cycle `valid` pulse, carrying read data on reads.
- Instantiated in the SoC/testbench opposite the core's data port; a second instance can serve the instruction port with `we` tied low.

Parameters:
- NBITS, 32: data and address width.
- DEPTH_WORDS, 1024: storage depth in words; must be a power of 2.
- LATENCY, 2: cycles from acceptance to `valid`; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- proc_req  in  1  request strobe from the core.
- addr  in  NBITS  byte address; word index = `addr[AW+1:2]`, where AW = $clog2(DEPTH_WORDS).
- we  in  1  1 = write, 0 = read.
- wdata  in  NBITS  write data.
- mem_rdy  out  1  responder can accept a request this cycle.
- valid  out  1  one-cycle completion pulse, for both reads and writes.
- rdata  out  NBITS  read data; meaningful only while `valid`=1 on a read.
- err  out  1  misaligned-access flag; present only with the optional feature, otherwise tied 0.

Behaviour:
- Reset (`rst`=1 at an edge):
  - state <= IDLE; `valid` <= 0; `rdata` <= 0; `err` <= 0; latency counter <= 0.
  - `mem_rdy` = (state==IDLE) && !rst, so it is 0 while `rst` is high.
  - Array contents are not reset.
- Acceptance: a request is accepted in cycle T when `proc_req`=1 and `mem_rdy`=1.
  - `addr`, `we` and `wdata` are captured at T; later changes are ignored.
  - `proc_req` while `mem_rdy`=0 is ignored and has no side effect.
- FSM states IDLE, WAIT, RESP:
  - IDLE: on accept, cnt <= LATENCY-1. Go to RESP if LATENCY==1, else WAIT.
  - WAIT: cnt decrements each cycle; go to RESP when cnt reaches 1.
  - RESP: `valid`=1 for exactly this cycle, then return to IDLE.
- Timing, accept at T:
  - `valid` is high in cycle T+LATENCY.
  - `mem_rdy` is low from T+1 through T+LATENCY and high again at T+LATENCY+1.
  - Maximum throughput is one transaction per LATENCY+1 cycles.
- Read: the array is read with the captured word index; `rdata` is registered and valid in the RESP cycle. `rdata` holds its last value outside RESP.
- Write: the array is written at the clock edge that ends the RESP cycle. A read accepted afterwards returns the new data. `rdata` is unchanged on writes.
- Address wrap: index bits above AW are ignored, so addresses alias modulo DEPTH_WORDS*4 bytes. `addr[1:0]` is ignored unless the optional feature is enabled.
- Reset mid-transaction: the transaction is abandoned, no `valid` is produced, and a pending write is not committed.
- Reset and request in the same cycle: `rst` wins and nothing is accepted.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined:
  - `addr[1:0]`!=0 at acceptance sets `err`=1 together with `valid` in the RESP cycle.
  - A misaligned write is suppressed; a misaligned read returns `rdata`=0.
  - `err` is 0 in all other cycles.
- Undefined: `err` is constant 0, and `addr[1:0]` is ignored.

Decomposition:
- Package dmem_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  - localparam LAT_MAX = 15;
  - function for the word-index width.
- Sub-module dmem_ram: single-port synchronous word array with `we`, `addr`, `wdata` and registered `rdata`. The FSM and counter stay in dmem_responder.

Test Plan:
- Reset, then idle: `mem_rdy`=0 during `rst`, 1 on the first cycle after; `valid`=0 and `rdata`=0 throughout.
- LATENCY=2: write 0xDEADBEEF to 0x40 accepted at T, then read 0x40 -> write `valid` at T+2; read accepted at T+3; `valid` at T+5 with `rdata`=0xDEADBEEF.
- LATENCY=1: back-to-back reads with `proc_req` held high -> accepts every 2 cycles; each `valid` is one cycle, exactly 1 cycle after its accept.
- Hold `proc_req`=1 with changing `addr`/`wdata` while `mem_rdy`=0 -> only the accepted request's values are used; no extra writes; array contents verified afterwards.
- DEPTH_WORDS=1024: write 0x11 to 0x0000_1000, read 0x0 -> `rdata`=0x11 (wrap/alias).
- Write accepted, `rst` pulsed during WAIT, then read same address -> no `valid` for the aborted write; old data returned. With DMEM_MISALIGN_ERR_EN: read of 0x42 -> `valid`=1, `err`=1, `rdata`=0.
